// File: rtl/comp_seq.sv
`default_nettype none
// ============================================================================
//  Module   : comp_seq
//  Brief    : Sequential magnitude comparator. Walks two captured unsigned
//             operands from the most significant 2-bit digit downward,
//             consulting an external 2-bit comparator slice once per cycle
//             and stopping at the first unequal digit.
//  Revision : 1.0  initial release
// ============================================================================
module comp_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [1:0]       o_dig_a,
  output logic [1:0]       o_dig_b,
  input  logic             i_slice_l,
  input  logic             i_slice_g,
  input  logic             i_slice_eq,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_lt,
  output logic             o_gt,
  output logic             o_eq
);

  localparam int DIGITS = WIDTH / 2;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             r_lt;
  logic             r_gt;
  logic             r_eq;
  logic             w_lt_nxt;
  logic             w_gt_nxt;
  logic             w_eq_nxt;
  logic [IDX_W:0]   w_bit;
  logic             w_dig_lt;
  logic             w_dig_gt;
  logic             w_dig_eq;

  // Bit position of the current digit's low bit (index * 2).
  assign w_bit = {r_idx, 1'b0};

  // Slice verdict with fixed priority less > greater > equal. An explicit
  // equal flag and a slice that reports nothing are both taken as equal.
  assign w_dig_lt = i_slice_l;
  assign w_dig_gt = ~i_slice_l & i_slice_g;
  assign w_dig_eq = (~i_slice_l & ~i_slice_g & i_slice_eq) |
                    (~i_slice_l & ~i_slice_g & ~i_slice_eq);

  // State register; reset aborts any comparison in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath-update decisions for the digit walk.
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_idx_nxt   = r_idx;
    w_lt_nxt    = r_lt;
    w_gt_nxt    = r_gt;
    w_eq_nxt    = r_eq;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_a_nxt     = i_a;
          w_b_nxt     = i_b;
          w_idx_nxt   = IDX_MSB;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_dig_lt) begin
          w_lt_nxt    = 1'b1;
          w_gt_nxt    = 1'b0;
          w_eq_nxt    = 1'b0;
          w_state_nxt = ST_DONE;
        end else if (w_dig_gt) begin
          w_lt_nxt    = 1'b0;
          w_gt_nxt    = 1'b1;
          w_eq_nxt    = 1'b0;
          w_state_nxt = ST_DONE;
        end else if (w_dig_eq && (r_idx != '0)) begin
          w_idx_nxt   = r_idx - 1'b1;
        end else begin
          // Every digit matched down to the least significant one.
          w_lt_nxt    = 1'b0;
          w_gt_nxt    = 1'b0;
          w_eq_nxt    = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        // Single result cycle; a start seen here is deliberately dropped.
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand, digit index and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_idx <= '0;
      r_lt  <= 1'b0;
      r_gt  <= 1'b0;
      r_eq  <= 1'b0;
    end else begin
      r_a   <= w_a_nxt;
      r_b   <= w_b_nxt;
      r_idx <= w_idx_nxt;
      r_lt  <= w_lt_nxt;
      r_gt  <= w_gt_nxt;
      r_eq  <= w_eq_nxt;
    end
  end

  // Digits go to the slice only while walking; parked at zero otherwise.
  assign o_dig_a = (r_state == ST_RUN) ? r_a[w_bit +: 2] : 2'b00;
  assign o_dig_b = (r_state == ST_RUN) ? r_b[w_bit +: 2] : 2'b00;

  assign o_busy  = (r_state == ST_RUN);
  assign o_done  = (r_state == ST_DONE);
  assign o_lt    = r_lt;
  assign o_gt    = r_gt;
  assign o_eq    = r_eq;

endmodule
`default_nettype wire

// File: tb/tb_comp_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_comp_seq
//  Brief    : Scoreboard bench for comp_seq (WIDTH=8). Stimulus queues the
//             expected result of each accepted start; a monitor checks every
//             RUN digit and every done pulse against the queue head.
//  Revision : 1.0  initial release
// ============================================================================
module tb_comp_seq;

  localparam int WIDTH  = 8;
  localparam int DIGITS = WIDTH / 2;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             lt;
    logic             gt;
    logic             eq;
    int               n;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic [1:0]       o_dig_a;
  logic [1:0]       o_dig_b;
  logic             i_slice_l;
  logic             i_slice_g;
  logic             i_slice_eq;
  logic             o_busy;
  logic             o_done;
  logic             o_lt;
  logic             o_gt;
  logic             o_eq;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   run_cnt = 0;

  comp_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (i_start),
    .i_a       (i_a),
    .i_b       (i_b),
    .o_dig_a   (o_dig_a),
    .o_dig_b   (o_dig_b),
    .i_slice_l (i_slice_l),
    .i_slice_g (i_slice_g),
    .i_slice_eq(i_slice_eq),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_lt      (o_lt),
    .o_gt      (o_gt),
    .o_eq      (o_eq)
  );

  // External 2-bit comparator slice.
  always_comb begin
    i_slice_l  = (o_dig_a <  o_dig_b);
    i_slice_g  = (o_dig_a >  o_dig_b);
    i_slice_eq = (o_dig_a == o_dig_b);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, o_done}, 32'd0);
    chk({tag, "_ltgteq"}, {29'd0, o_lt, o_gt, o_eq}, 32'd0);
    chk({tag, "_dig"}, {28'd0, o_dig_a, o_dig_b}, 32'd0);
  endtask

  // Monitor: checks digits while busy, result and latency on done.
  always @(negedge clk) begin
    logic [WIDTH-1:0] ea;
    logic [WIDTH-1:0] eb;
    int               idx;
    if (!rst_n) begin
      run_cnt = 0;
    end else if (o_busy) begin
      if (q.size() == 0) begin
        chk("busy_without_request", 32'd1, 32'd0);
      end else begin
        idx = DIGITS - 1 - run_cnt;
        if (idx < 0) begin
          chk("run_too_long", run_cnt, q[0].n);
        end else begin
          ea = q[0].a;
          eb = q[0].b;
          chk("dig_a", {30'd0, o_dig_a}, {30'd0, ea[2*idx +: 2]});
          chk("dig_b", {30'd0, o_dig_b}, {30'd0, eb[2*idx +: 2]});
        end
      end
      chk("busy_done_overlap", {31'd0, o_done}, 32'd0);
      run_cnt++;
    end else if (o_done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result_lt_gt_eq", {29'd0, o_lt, o_gt, o_eq}, {29'd0, e.lt, e.gt, e.eq});
        chk("busy_cycles", run_cnt, e.n);
        chk("dig_idle_in_done", {28'd0, o_dig_a, o_dig_b}, 32'd0);
      end
      run_cnt = 0;
    end
  end

  // Wait until every queued result has been seen and the DUT is idle.
  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #2;
      if (q.size() == 0 && !o_busy && !o_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk({tag, "_timeout"}, 32'd1, 32'd0);
      q.delete();
    end
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic lt, input logic gt, input logic eq, input int n);
    exp_t e;
    e.a = a; e.b = b; e.lt = lt; e.gt = gt; e.eq = eq; e.n = n;
    q.push_back(e);
  endtask

  // One start pulse; operands are scrambled right after acceptance so the
  // digit checks prove the captured copy is what gets compared.
  task automatic run_cmp(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic lt, input logic gt, input logic eq, input int n);
    push_exp(a, b, lt, gt, eq, n);
    i_a     = a;
    i_b     = b;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_a     = ~a;
    i_b     = a ^ b ^ 8'h3C;
    chk({tag, "_accepted"}, {31'd0, o_busy}, 32'd1);
    wait_idle(tag);
  endtask

  initial begin
    rst_n   = 1'b0;
    i_start = 1'b0;
    i_a     = '0;
    i_b     = '0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset_held");
    rst_n = 1'b1;

    // Directed vectors: {a, b, lt, gt, eq, digits examined}.
    run_cmp("eq_A5",   8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1, 4);
    run_cmp("gt_80_40", 8'h80, 8'h40, 1'b0, 1'b1, 1'b0, 1);
    run_cmp("lt_1C_1D", 8'h1C, 8'h1D, 1'b1, 1'b0, 1'b0, 4);
    run_cmp("lt_37_3F", 8'h37, 8'h3F, 1'b1, 1'b0, 1'b0, 3);
    run_cmp("gt_9F_8F", 8'h9F, 8'h8F, 1'b0, 1'b1, 1'b0, 2);
    run_cmp("eq_00",   8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 4);

    // Start held for 10 edges: accepted at E0, E3, E6, E9 only.
    for (int k = 0; k < 4; k++) push_exp(8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1);
    i_a     = 8'h00;
    i_b     = 8'hFF;
    i_start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    i_start = 1'b0;
    wait_idle("held_start");

    // Reset in the middle of a walk: everything clears, result discarded.
    push_exp(8'h55, 8'h56, 1'b1, 1'b0, 1'b0, 4);
    i_a     = 8'h55;
    i_b     = 8'h56;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_abort_busy", {31'd0, o_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    q.delete();
    @(posedge clk);
    #1;
    chk_all_zero("abort_held");
    rst_n = 1'b1;
    run_cmp("after_abort", 8'h55, 8'h56, 1'b1, 1'b0, 1'b0, 4);

    repeat (3) @(posedge clk);
    #1;
    chk("leftover_expectations", q.size(), 32'd0);
    chk("final_result_held", {29'd0, o_lt, o_gt, o_eq}, 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/comp_seq.md
COMP_SEQ -- requirements
Module: comp_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; SHALL be even and >= 4.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to compare a against b; sampled on rising edge.
REQ-005 a  input  WIDTH  first operand, unsigned, captured when start is accepted.
REQ-006 b  input  WIDTH  second operand, unsigned, captured when start is accepted.
REQ-007 dig_a  output  2  current 2-bit digit of captured a, driven to the external 2-bit comparator slice.
REQ-008 dig_b  output  2  current 2-bit digit of captured b, driven to the same slice.
REQ-009 slice_l  input  1  slice result: dig_a < dig_b (combinational return from the slice).
REQ-010 slice_g  input  1  slice result: dig_a > dig_b.
REQ-011 slice_eq  input  1  slice result: dig_a == dig_b.
REQ-012 busy  output  1  high while a comparison is in progress.
REQ-013 done  output  1  one-cycle pulse marking a new result.
REQ-014 lt, gt, eq  output  1 each  registered result, one-hot after the first completion, held until the next completion.

Function
REQ-015 The block SHALL be a three-state FSM: IDLE, RUN, DONE.
REQ-016 In IDLE with start=1, the block SHALL capture a and b, set the digit index to WIDTH/2-1 (MSB digit), and enter RUN.
REQ-017 start SHALL be ignored in RUN and DONE; captured operands SHALL NOT change until the next accepted start.
REQ-018 In RUN, dig_a/dig_b SHALL equal bits [2i+1:2i] of captured a/b for index i, combinationally from the index register; outside RUN both SHALL be 2'b00.
REQ-019 Each RUN cycle SHALL evaluate one digit using priority slice_l > slice_g > slice_eq; with none asserted, the digit SHALL be treated as equal.
REQ-020 Digit less: lt<=1, gt<=0, eq<=0, enter DONE (early termination).
REQ-021 Digit greater: gt<=1, lt<=0, eq<=0, enter DONE (early termination).
REQ-022 Digit equal with i>0: index SHALL decrement by 1 and the FSM SHALL stay in RUN.
REQ-023 Digit equal with i==0: eq<=1, lt<=0, gt<=0, enter DONE.
REQ-024 lt/gt/eq SHALL update only on the edge entering DONE; done SHALL be high exactly during the DONE cycle.
REQ-025 Latency: with start sampled at edge E0, done SHALL be high after edge En, where n = digits examined (1..WIDTH/2).
REQ-026 DONE SHALL return to IDLE after one cycle unconditionally; a start in that cycle SHALL be ignored.
REQ-027 busy SHALL be 1 exactly when the state is RUN.
REQ-028 Minimum start-to-start spacing for back-to-back comparisons SHALL be n+2 cycles.

Reset
REQ-029 rst_n=0 SHALL, asynchronously and in any state including mid-RUN, force IDLE, index 0, operand registers 0, and busy=0, done=0, lt=0, gt=0, eq=0, dig_a=dig_b=2'b00.
REQ-030 After rst_n rises, the first start SHALL be accepted on the first rising edge with start=1.

Verification (WIDTH=8, bench models the slice from dig_a/dig_b)
REQ-031 a=0xA5, b=0xA5, start pulse -> 4 RUN cycles, busy high 4 cycles, done after edge E4, eq=1, lt=gt=0.
REQ-032 a=0x80, b=0x40 -> first digit 10 vs 01, done after E1, gt=1; dig_a/dig_b return to 00 in DONE.
REQ-033 a=0x1C, b=0x1D -> digits equal until the last (00 vs 01), done after E4, lt=1.
REQ-034 a=0x00, b=0xFF, start held high 10 cycles -> lt=1 after E1, exactly one done pulse per accepted start; starts in RUN/DONE ignored.
REQ-035 Start a=0x55, b=0x56, assert rst_n=0 after E2 -> all outputs 0 immediately, no done pulse; a new start after release compares correctly (lt=1 after E4).
